// File: rtl/fetch_unit_pkg.sv
// Shared fetch definitions: NOP encoding, fetch FSM states, default reset vector and a saturating counter helper.
package fetch_unit_pkg;
  localparam logic [31:0] NOP                  = 32'h0000_0013;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    FS_BOOT = 3'd0,
    FS_IDLE = 3'd1,
    FS_REQ  = 3'd2,
    FS_WAIT = 3'd3,
    FS_DROP = 3'd4
  } fetch_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry instr+pc buffer parking a fetch response while decode is stalled.
// Data is visible the cycle after push; flush beats push, push beats pop.
module fetch_hold_buf import fetch_unit_pkg::*; #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  logic [XLEN-1:0] push_instr,
  input  logic [XLEN-1:0] push_pc,
  output logic            full,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc
);
  logic            full_q, full_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;

  always_comb begin
    full_d  = full_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush) begin
      full_d = 1'b0;
    end else if (push) begin
      full_d  = 1'b1;
      instr_d = push_instr;
      pc_d    = push_pc;
    end else if (pop) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      instr_q <= XLEN'(NOP);
      pc_q    <= '0;
    end else begin
      full_q  <= full_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign full  = full_q;
  assign instr = instr_q;
  assign pc    = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// PC generation, single-outstanding imem fetch and IF/ID register; response reaches IF/ID one cycle after rvalid.
// pc_stall parks a response in the hold buffer and blocks new requests; FETCH_PERF_EN adds fetched/dropped counters.
module fetch_unit import fetch_unit_pkg::*; #(
  parameter int unsigned          XLEN         = 32,
  parameter logic [XLEN-1:0]      RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_stall,
  input  logic            flush_fe,
  input  logic            flush_dec,
  input  logic            taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc,
  output logic            dec_valid,
  output logic            fetch_busy
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_dropped
`endif
);
  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            redirect_pend_q, redirect_pend_d;
  logic [XLEN-1:0] dec_instr_q, dec_instr_d;
  logic [XLEN-1:0] dec_pc_q, dec_pc_d;
  logic            dec_valid_q, dec_valid_d;

  logic            kill, deliver, discard, can_fetch;
  logic            hb_push, hb_pop, hb_flush, hb_full;
  logic [XLEN-1:0] hb_instr, hb_pc;

  assign kill     = taken | flush_fe;
  assign deliver  = imem_rvalid & (state_q == FS_WAIT) & ~kill;
  assign discard  = imem_rvalid & (((state_q == FS_WAIT) & kill) | (state_q == FS_DROP));
  assign hb_push  = deliver & (pc_stall | flush_dec);
  assign hb_pop   = hb_full & ~pc_stall & ~flush_dec;
  assign hb_flush = kill;
  // Fetch may proceed only if the hold buffer will be empty after this cycle.
  assign can_fetch = ~pc_stall & ~(~hb_flush & (hb_push | (hb_full & ~hb_pop)));

  fetch_hold_buf #(.XLEN(XLEN)) u_hold_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (hb_push),
    .pop        (hb_pop),
    .flush      (hb_flush),
    .push_instr (imem_rdata),
    .push_pc    (inflight_pc_q),
    .full       (hb_full),
    .instr      (hb_instr),
    .pc         (hb_pc)
  );

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    redirect_pend_d = redirect_pend_q;
    inflight_pc_d   = inflight_pc_q;
    if (taken) pc_d = branch_target;
    unique case (state_q)
      FS_BOOT: state_d = FS_REQ;
      FS_IDLE: if (can_fetch) state_d = FS_REQ;
      FS_REQ: begin
        if (imem_gnt) begin
          state_d = (kill || redirect_pend_q) ? FS_DROP : FS_WAIT;
          // A pending redirect already holds the target in pc.
          if (!taken && !redirect_pend_q) pc_d = pc_q + XLEN'(4);
        end else if (taken) begin
          redirect_pend_d = 1'b1;
        end
      end
      FS_WAIT: begin
        if (imem_rvalid) state_d = can_fetch ? FS_REQ : FS_IDLE;
        else if (kill)   state_d = FS_DROP;
      end
      FS_DROP: begin
        if (imem_rvalid) begin
          redirect_pend_d = 1'b0;
          state_d         = can_fetch ? FS_REQ : FS_IDLE;
        end
      end
      default: state_d = FS_BOOT;
    endcase
    // The request address is latched on entry and held until the response returns.
    if (state_d == FS_REQ && state_q != FS_REQ) inflight_pc_d = pc_d;
  end

  always_comb begin
    dec_instr_d = dec_instr_q;
    dec_pc_d    = dec_pc_q;
    dec_valid_d = dec_valid_q;
    if (flush_dec) begin
      dec_instr_d = XLEN'(NOP);
      dec_valid_d = 1'b0;
    end else if (!pc_stall) begin
      if (hb_full && !kill) begin
        dec_instr_d = hb_instr;
        dec_pc_d    = hb_pc;
        dec_valid_d = 1'b1;
      end else if (deliver) begin
        dec_instr_d = imem_rdata;
        dec_pc_d    = inflight_pc_q;
        dec_valid_d = 1'b1;
      end else begin
        dec_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= FS_BOOT;
      pc_q            <= RESET_VECTOR;
      inflight_pc_q   <= RESET_VECTOR;
      redirect_pend_q <= 1'b0;
      dec_instr_q     <= XLEN'(NOP);
      dec_pc_q        <= '0;
      dec_valid_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      inflight_pc_q   <= inflight_pc_d;
      redirect_pend_q <= redirect_pend_d;
      dec_instr_q     <= dec_instr_d;
      dec_pc_q        <= dec_pc_d;
      dec_valid_q     <= dec_valid_d;
    end
  end

  assign imem_req   = (state_q == FS_REQ);
  assign imem_addr  = inflight_pc_q;
  assign fetch_busy = (state_q == FS_REQ) | (state_q == FS_WAIT) | (state_q == FS_DROP);
  assign dec_instr  = dec_instr_q;
  assign dec_pc     = dec_pc_q;
  assign dec_valid  = dec_valid_q;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_dropped_q, perf_dropped_d;

  always_comb begin
    perf_fetched_d = deliver ? sat_inc(perf_fetched_q) : perf_fetched_q;
    perf_dropped_d = discard ? sat_inc(perf_dropped_q) : perf_dropped_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_dropped_q <= perf_dropped_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_dropped = perf_dropped_q;
`else
  logic unused_discard;
  assign unused_discard = discard;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a second instance with a high reset vector checks pc wrap.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n, pc_stall, flush_fe, flush_dec, taken, imem_gnt;
  logic [31:0] branch_target;
  logic        imem_req, imem_rvalid, dec_valid, fetch_busy;
  logic [31:0] imem_addr, imem_rdata, dec_instr, dec_pc;
  logic        req2, rvalid2, dec_valid2, busy2;
  logic [31:0] addr2, rdata2, dec_instr2, dec_pc2;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_dropped, perf_fetched2, perf_dropped2;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int lat    = 1;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .pc_stall(pc_stall), .flush_fe(flush_fe), .flush_dec(flush_dec),
    .taken(taken), .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_valid(dec_valid), .fetch_busy(fetch_busy)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_dropped(perf_dropped)
`endif
  );

  fetch_unit #(.RESET_VECTOR(32'hFFFF_FFF8)) dut_hi (
    .clk(clk), .rst_n(rst_n), .pc_stall(pc_stall), .flush_fe(flush_fe), .flush_dec(flush_dec),
    .taken(taken), .branch_target(branch_target), .imem_req(req2), .imem_addr(addr2),
    .imem_gnt(imem_gnt), .imem_rvalid(rvalid2), .imem_rdata(rdata2),
    .dec_instr(dec_instr2), .dec_pc(dec_pc2), .dec_valid(dec_valid2), .fetch_busy(busy2)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched2), .perf_dropped(perf_dropped2)
`endif
  );

  // Memory model: rdata = address, response 'lat' cycles after the grant.
  logic        s1_v = 1'b0, s2_v = 1'b0, t1_v = 1'b0, t2_v = 1'b0;
  logic [31:0] s1_a = '0, s2_a = '0, t1_a = '0, t2_a = '0;
  initial begin
    imem_rvalid = 1'b0; imem_rdata = '0; rvalid2 = 1'b0; rdata2 = '0;
    forever begin
      @(posedge clk);
      s2_v = s1_v; s2_a = s1_a; s1_v = imem_req && imem_gnt; s1_a = imem_addr;
      t2_v = t1_v; t2_a = t1_a; t1_v = req2 && imem_gnt;     t1_a = addr2;
      #1;
      imem_rvalid = (lat == 1) ? s1_v : s2_v;
      imem_rdata  = (lat == 1) ? s1_a : s2_a;
      rvalid2     = (lat == 1) ? t1_v : t2_v;
      rdata2      = (lat == 1) ? t1_a : t2_a;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; pc_stall = 1'b0; flush_fe = 1'b0; flush_dec = 1'b0; taken = 1'b0;
    branch_target = '0; imem_gnt = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b exp 0", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h exp 0", imem_addr); end
    n_cmp++; if (dec_instr !== 32'h13) begin n_fail++; $display("FAIL rst_instr: got %h exp 13", dec_instr); end
    n_cmp++; if (dec_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h exp 0", dec_pc); end
    n_cmp++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", dec_valid); end
    n_cmp++; if (fetch_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b exp 0", fetch_busy); end
    n_cmp++; if (addr2 !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL rst_addr_hi: got %h exp fffffff8", addr2); end
  endtask

  task automatic test_sequential();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL seq_a0: req %b addr %h exp 1/0", imem_req, imem_addr); end
    n_cmp++; if (addr2 !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL seq_hi0: got %h exp fffffff8", addr2); end
    @(negedge clk);
    n_cmp++; if (fetch_busy !== 1'b1 || imem_req !== 1'b0 || dec_valid !== 1'b0) begin n_fail++; $display("FAIL seq_wait: busy %b req %b valid %b exp 1/0/0", fetch_busy, imem_req, dec_valid); end
    @(negedge clk);
    n_cmp++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0 || dec_instr !== 32'h0) begin n_fail++; $display("FAIL seq_dec0: valid %b pc %h instr %h exp 1/0/0", dec_valid, dec_pc, dec_instr); end
    n_cmp++; if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL seq_a4: got %h exp 4", imem_addr); end
    n_cmp++; if (addr2 !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL seq_hi1: got %h exp fffffffc", addr2); end
    @(negedge clk);
    n_cmp++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL seq_bubble: got %b exp 0", dec_valid); end
    @(negedge clk);
    n_cmp++; if (dec_valid !== 1'b1 || dec_pc !== 32'h4) begin n_fail++; $display("FAIL seq_dec4: valid %b pc %h exp 1/4", dec_valid, dec_pc); end
    n_cmp++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL seq_a8: got %h exp 8", imem_addr); end
    n_cmp++; if (addr2 !== 32'h0) begin n_fail++; $display("FAIL seq_hi_wrap: got %h exp 0", addr2); end
`ifdef FETCH_PERF_EN
    n_cmp++; if (perf_fetched !== 32'd2) begin n_fail++; $display("FAIL seq_perf_fetched: got %0d exp 2", perf_fetched); end
`endif
  endtask

  task automatic test_taken_wait();
    lat = 2;
    @(negedge clk);
    n_cmp++; if (fetch_busy !== 1'b1 || imem_req !== 1'b0 || imem_addr !== 32'h8) begin n_fail++; $display("FAIL tw_wait8: busy %b req %b addr %h exp 1/0/8", fetch_busy, imem_req, imem_addr); end
    taken = 1'b1; branch_target = 32'h100;
    @(negedge clk);
    taken = 1'b0;
    n_cmp++; if (fetch_busy !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL tw_drop: busy %b req %b exp 1/0", fetch_busy, imem_req); end
    @(negedge clk);
    lat = 1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL tw_redirect: req %b addr %h exp 1/100", imem_req, imem_addr); end
    n_cmp++; if (dec_valid !== 1'b0 || dec_pc !== 32'h4) begin n_fail++; $display("FAIL tw_nodeliver: valid %b pc %h exp 0/4", dec_valid, dec_pc); end
`ifdef FETCH_PERF_EN
    n_cmp++; if (perf_dropped !== 32'd1) begin n_fail++; $display("FAIL tw_perf_dropped: got %0d exp 1", perf_dropped); end
`endif
    repeat (2) @(negedge clk);
    n_cmp++; if (dec_valid !== 1'b1 || dec_pc !== 32'h100 || dec_instr !== 32'h100) begin n_fail++; $display("FAIL tw_dec100: valid %b pc %h instr %h exp 1/100/100", dec_valid, dec_pc, dec_instr); end
    n_cmp++; if (imem_addr !== 32'h104) begin n_fail++; $display("FAIL tw_a104: got %h exp 104", imem_addr); end
  endtask

  task automatic test_taken_req_nogrant();
    imem_gnt = 1'b0; taken = 1'b1; branch_target = 32'h200;
    @(negedge clk);
    taken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin n_fail++; $display("FAIL tr_hold%0d: req %b addr %h exp 1/104", i, imem_req, imem_addr); end
      if (i < 2) @(negedge clk);
    end
    imem_gnt = 1'b1;
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b0 || fetch_busy !== 1'b1) begin n_fail++; $display("FAIL tr_drop: req %b busy %b exp 0/1", imem_req, fetch_busy); end
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_fail++; $display("FAIL tr_redirect: req %b addr %h exp 1/200", imem_req, imem_addr); end
    n_cmp++; if (dec_valid !== 1'b0 || dec_pc !== 32'h100) begin n_fail++; $display("FAIL tr_nodeliver: valid %b pc %h exp 0/100", dec_valid, dec_pc); end
`ifdef FETCH_PERF_EN
    n_cmp++; if (perf_dropped !== 32'd2) begin n_fail++; $display("FAIL tr_perf_dropped: got %0d exp 2", perf_dropped); end
`endif
  endtask

  task automatic test_stall_hold();
    @(negedge clk);
    n_cmp++; if (fetch_busy !== 1'b1 || imem_req !== 1'b0 || imem_addr !== 32'h200) begin n_fail++; $display("FAIL st_wait: busy %b req %b addr %h exp 1/0/200", fetch_busy, imem_req, imem_addr); end
    pc_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (imem_req !== 1'b0 || dec_pc !== 32'h100 || dec_valid !== 1'b0) begin n_fail++; $display("FAIL st_hold%0d: req %b pc %h valid %b exp 0/100/0", i, imem_req, dec_pc, dec_valid); end
    end
    pc_stall = 1'b0;
    @(negedge clk);
    n_cmp++; if (dec_valid !== 1'b1 || dec_pc !== 32'h200 || dec_instr !== 32'h200) begin n_fail++; $display("FAIL st_drain: valid %b pc %h instr %h exp 1/200/200", dec_valid, dec_pc, dec_instr); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h204) begin n_fail++; $display("FAIL st_resume: req %b addr %h exp 1/204", imem_req, imem_addr); end
  endtask

  task automatic test_load_use();
    pc_stall = 1'b1; flush_dec = 1'b1; imem_gnt = 1'b0;
    @(negedge clk);
    n_cmp++; if (dec_instr !== 32'h13 || dec_valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble: instr %h valid %b exp 13/0", dec_instr, dec_valid); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h204) begin n_fail++; $display("FAIL lu_pc: req %b addr %h exp 1/204", imem_req, imem_addr); end
    pc_stall = 1'b0; flush_dec = 1'b0; imem_gnt = 1'b1;
    @(negedge clk);
    n_cmp++; if (fetch_busy !== 1'b1 || imem_req !== 1'b0 || dec_valid !== 1'b0) begin n_fail++; $display("FAIL lu_wait: busy %b req %b valid %b exp 1/0/0", fetch_busy, imem_req, dec_valid); end
    @(negedge clk);
    n_cmp++; if (dec_valid !== 1'b1 || dec_pc !== 32'h204 || imem_addr !== 32'h208) begin n_fail++; $display("FAIL lu_resume: valid %b pc %h addr %h exp 1/204/208", dec_valid, dec_pc, imem_addr); end
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || fetch_busy !== 1'b0) begin n_fail++; $display("FAIL rm_fetch: req %b addr %h busy %b exp 0/0/0", imem_req, imem_addr, fetch_busy); end
    n_cmp++; if (dec_valid !== 1'b0 || dec_instr !== 32'h13 || dec_pc !== 32'h0) begin n_fail++; $display("FAIL rm_dec: valid %b instr %h pc %h exp 0/13/0", dec_valid, dec_instr, dec_pc); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL rm_reboot: req %b addr %h exp 1/0", imem_req, imem_addr); end
  endtask

  task automatic test_flush_fe();
    @(negedge clk);
    flush_fe = 1'b1;
    @(negedge clk);
    flush_fe = 1'b0;
    n_cmp++; if (dec_valid !== 1'b0 || dec_pc !== 32'h0) begin n_fail++; $display("FAIL ff_discard: valid %b pc %h exp 0/0", dec_valid, dec_pc); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL ff_next: req %b addr %h exp 1/4", imem_req, imem_addr); end
`ifdef FETCH_PERF_EN
    n_cmp++; if (perf_dropped !== 32'd1 || perf_fetched !== 32'd0) begin n_fail++; $display("FAIL ff_perf: dropped %0d fetched %0d exp 1/0", perf_dropped, perf_fetched); end
`endif
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_taken_wait();
    test_taken_req_nogrant();
    test_stall_hold();
    test_load_use();
    test_reset_mid();
    test_flush_fe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
